winograd_accumulator: RTL
=========================

// Module: winograd_accumulator
// PURPOSE
//   Downstream stage of the Winograd datapath. Consumes the two signed output
//   sums of the Winograd core and accumulates a programmable number of them
//   per lane (reduction over input-channel tiles). Emits the two accumulated
//   results through a valid/ready handshake and back-pressures the producer
//   while a result is unconsumed.
// PARAMETERS
//   IN_SIZE   24  width of each Winograd output lane, two's complement
//   ACC_SIZE  32  accumulator/output width, ACC_SIZE >= IN_SIZE
//   CNT_SIZE  8   width of the term-count field len_i
// PORTS
//   clk_i       in   1          clock, rising edge
//   rst_ni      in   1          reset, asynchronous, active-low
//   flush_i     in   1          synchronous abort, drops partial sums and result
//   len_i       in   CNT_SIZE   terms per result, sampled on first accepted beat
//   in_valid_i  in   1          in_data_i valid (aligned to Winograd out_o)
//   in_ready_o  out  1          accumulator accepts a beat this cycle
//   in_data_i   in   IN_SIZE    [0:1] two lane sums from the Winograd core
//   out_valid_o out  1          accumulated result available
//   out_ready_i in   1          consumer takes result this cycle
//   out_data_o  out  ACC_SIZE   [0:1] accumulated lane results
//   busy_o      out  1          state != IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, acc[0:1]=0, cnt=0, len_q=0, out_valid_o=0,
//     out_data_o=0, busy_o=0. in_ready_o=1 is derived from state.
//   - Accept = in_valid_i & in_ready_o. out_fire = out_valid_o & out_ready_i.
//   - Arithmetic: in_data_i is sign-extended to ACC_SIZE. Sums wrap modulo
//     2^ACC_SIZE with no saturation and no overflow flag. Lanes are independent.
//   - len_i=0 is treated as 1.
//   - FSM IDLE / ACCUM / HOLD:
//     IDLE : in_ready_o=1. On accept: acc=sext(in), cnt=1, len_q=max(len_i,1).
//            Go to HOLD if len_q==1, else to ACCUM.
//     ACCUM: in_ready_o=1. On accept: acc+=sext(in), cnt++. Go to HOLD when
//            cnt+1==len_q. Gaps (in_valid_i=0) hold all state.
//     HOLD : out_valid_o=1, out_data_o=acc (registered, stable until fire).
//            in_ready_o=out_ready_i (combinational).
//            out_fire without accept -> IDLE.
//            out_fire with accept -> same as an IDLE accept: new len_i sampled,
//            acc reloaded, no bubble.
//   - Latency: last accepted beat at cycle N gives out_valid_o=1 at N+1.
//     Throughput is one beat per cycle, including back-to-back results.
//   - out_valid_o never drops without out_fire, except on flush_i or reset.
//   - flush_i has priority over every other event. Next state is IDLE, acc=0,
//     cnt=0, out_valid_o=0. A beat presented in the same cycle is discarded;
//     in_ready_o stays per current state.
//   - Reset asserted mid-accumulation or in HOLD: outputs return to their reset
//     values immediately (asynchronous), and the pending result is lost.
//   - len_i changes after the first beat of a result are ignored until the
//     next result starts.
// TESTING
//   1. len=4, beats {1,-1},{2,-2},{3,-3},{4,-4}, out_ready=1 -> one cycle
//      after beat 4: out_valid=1, out_data={10,-10}, then IDLE.
//   2. len=1, four back-to-back beats {5,7}, out_ready=1 -> out_valid held
//      high four cycles, each {5,7}, no bubbles. len=0 behaves identically.
//   3. len=2, out_ready=0 for 5 cycles after the result -> out_valid=1 and data
//      stable, in_ready=0 in HOLD, result delivered when out_ready rises.
//   4. Wrap: ACC_SIZE=IN_SIZE=24, len=2, beats 0x7FFFFF,1 per lane ->
//      out_data=0x800000 (modular wrap, no saturation).
//   5. flush_i after 2 of 4 beats -> IDLE, busy=0. A fresh len=2 run {3,3},
//      {4,4} -> {7,7}, with no leftover from the aborted run.
//   6. rst_ni pulsed low while in HOLD with out_valid=1 -> out_valid=0,
//      out_data=0 without a clock edge. A clean run after release is correct.

Source files
------------

// File: rtl/winograd_accumulator_if.sv
// Handshake bundle between the Winograd core, the accumulator and its consumer.
//   flush_i     : synchronous abort of the partial sums and any held result
//   len_i       : terms per result, sampled on the first accepted beat
//   in_valid_i  : in_data_i valid
//   in_ready_o  : accumulator accepts a beat this cycle
//   in_data_i   : two signed lane sums from the Winograd core
//   out_valid_o : accumulated result available
//   out_ready_i : consumer takes the result this cycle
//   out_data_o  : two accumulated lane results
//   busy_o      : accumulator is not idle
// The suffixes are as seen from the accumulator. The accumulator uses the
// slave modport and the environment driving it uses the master modport.
interface winograd_accumulator_if #(
    parameter int unsigned IN_SIZE  = 24,
    parameter int unsigned ACC_SIZE = 32,
    parameter int unsigned CNT_SIZE = 8
);
    logic                           flush_i;
    logic [CNT_SIZE-1:0]            len_i;
    logic                           in_valid_i;
    logic                           in_ready_o;
    logic [0:1][IN_SIZE-1:0]        in_data_i;
    logic                           out_valid_o;
    logic                           out_ready_i;
    logic [0:1][ACC_SIZE-1:0]       out_data_o;
    logic                           busy_o;

    modport master (
        output flush_i, len_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, busy_o
    );

    modport slave (
        input  flush_i, len_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, busy_o
    );
endinterface

// File: rtl/winograd_accumulator.sv
// Accumulates a programmable number of two-lane Winograd output beats and
// presents the result through a valid/ready handshake.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus_io : slave side of winograd_accumulator_if (input stream, output
//            stream, len, flush, busy)
// Inputs are sign-extended to ACC_SIZE and summed with modular wrap; the two
// lanes are independent. A result is held until the consumer takes it, and a
// new run may start in the same cycle the held result is taken.
module winograd_accumulator #(
    parameter int unsigned IN_SIZE  = 24,
    parameter int unsigned ACC_SIZE = 32,
    parameter int unsigned CNT_SIZE = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    winograd_accumulator_if.slave  bus_io
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e                   state_q, state_d;
    logic [0:1][ACC_SIZE-1:0] acc_q, acc_d;
    logic [CNT_SIZE-1:0]      cnt_q, cnt_d;
    logic [CNT_SIZE-1:0]      len_q, len_d;

    logic                     in_ready;
    logic                     out_valid;
    logic                     busy;
    logic                     accept;
    logic                     out_fire;
    logic [CNT_SIZE-1:0]      len_eff;
    logic [0:1][ACC_SIZE-1:0] in_ext;

    // A length of zero is treated as a single-term result.
    always_comb begin
        len_eff = (bus_io.len_i == '0) ? CNT_SIZE'(1) : bus_io.len_i;
    end

    always_comb begin
        in_ext = '0;
        for (int l = 0; l < 2; l++) begin
            in_ext[l] = ACC_SIZE'($signed(bus_io.in_data_i[l]));
        end
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            StIdle, StAccum: begin
                in_ready = 1'b1;
            end
            StHold: begin
                // Back-pressure the producer until the held result is taken.
                in_ready  = bus_io.out_ready_i;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
        busy = (state_q != StIdle);
    end

    assign accept   = bus_io.in_valid_i & in_ready;
    assign out_fire = out_valid & bus_io.out_ready_i;

    // Next-state logic; flush overrides every other event.
    always_comb begin
        state_d = state_q;
        if (bus_io.flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d = (len_eff == CNT_SIZE'(1)) ? StHold : StAccum;
                    end
                end
                StAccum: begin
                    if (accept && ((cnt_q + CNT_SIZE'(1)) == len_q)) begin
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (out_fire) begin
                        if (accept) begin
                            state_d = (len_eff == CNT_SIZE'(1)) ? StHold : StAccum;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath next-state. An accept in HOLD can only happen together with
    // out_fire, so it starts a fresh result exactly like an accept in IDLE.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        len_d = len_q;
        if (bus_io.flush_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (state_q == StAccum) begin
                for (int l = 0; l < 2; l++) begin
                    acc_d[l] = acc_q[l] + in_ext[l];
                end
                cnt_d = cnt_q + CNT_SIZE'(1);
            end else begin
                acc_d = in_ext;
                cnt_d = CNT_SIZE'(1);
                len_d = len_eff;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign bus_io.in_ready_o  = in_ready;
    assign bus_io.out_valid_o = out_valid;
    assign bus_io.out_data_o  = acc_q;
    assign bus_io.busy_o      = busy;

endmodule
